delay_timer_bank: RTL and testbench

//  Bank of NCH independent down-counting delay timers. Each channel loads a cycle count and

---
 rtl/delay_timer_bank.sv | 125 ++++++++++++
 tb/tb_delay_timer_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_bank.sv
// ---------------------------------------------------------------------------
// delay_timer_bank
//   Bank of NCH independent down-counting delay timers. A channel loads a
//   cycle count N on start, counts down to zero and then emits a one-cycle
//   registered done pulse, either returning to IDLE (one-shot) or reloading
//   N and continuing (periodic). Cancel aborts a running channel silently.
//   Start N on edge k -> done high between edges k+N+1 and k+N+2.
//
// Parameters
//   NCH     number of independent channels (>=1)
//   CW      counter width per channel; maximum delay 2**CW-1
//   RETRIG  1: start while running reloads; 0: start while running ignored
//
// Ports
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous reset, active-high
//   start     in   NCH      per-channel start strobe
//   cancel    in   NCH      per-channel abort strobe
//   periodic  in   NCH      mode captured at start (1 = auto-reload)
//   count     in   NCH*CW   delay for channel i in [i*CW +: CW]
//   busy      out  NCH      channel running (this is the per-channel FSM state)
//   done      out  NCH      one-cycle expiry pulse, registered
//   remain    out  NCH*CW   current down-counter value per channel
//   any_done  out  1        OR of done, registered in the same cycle as done
//
// Request semantics: start and cancel are single-cycle strobes sampled on
// every rising edge; there is no ready/acknowledge. A start is accepted when
// the channel is IDLE with cancel low, or when RUN with RETRIG=1 and cancel
// low. An unaccepted start is dropped, never queued. cancel always wins.
// ---------------------------------------------------------------------------
module delay_timer_bank #(
  parameter int NCH    = 2,
  parameter int CW     = 8,
  parameter bit RETRIG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    cancel,
  input  logic [NCH-1:0]    periodic,
  input  logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    done,
  output logic [NCH*CW-1:0] remain,
  output logic              any_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // One state bit per channel; the vector is driven straight onto busy so
  // the FSM state of every channel is directly observable.
  logic [NCH-1:0]         state,  state_n;
  logic [NCH-1:0][CW-1:0] cnt,    cnt_n;
  logic [NCH-1:0][CW-1:0] period, period_n;
  logic [NCH-1:0]         mode,   mode_n;
  logic [NCH-1:0]         done_r, done_n;
  logic                   any_done_r;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period;
    mode_n   = mode;
    done_n   = '0;
    for (int i = 0; i < NCH; i++) begin
      case (state[i])
        ST_IDLE: begin
          // cnt is already 0 here: every path into IDLE leaves it at 0.
          if (!cancel[i] && start[i]) begin
            state_n[i]  = ST_RUN;
            cnt_n[i]    = count[i*CW +: CW];
            period_n[i] = count[i*CW +: CW];
            mode_n[i]   = periodic[i];
          end
        end
        default: begin
          if (cancel[i]) begin
            state_n[i] = ST_IDLE;
            cnt_n[i]   = '0;
          end else if (start[i] && RETRIG) begin
            // Retrigger beats expiry: no done even if cnt is 0 this edge.
            cnt_n[i]    = count[i*CW +: CW];
            period_n[i] = count[i*CW +: CW];
            mode_n[i]   = periodic[i];
          end else if (cnt[i] == '0) begin
            done_n[i] = 1'b1;
            if (mode[i]) begin
              cnt_n[i] = period[i];
            end else begin
              state_n[i] = ST_IDLE;
            end
          end else begin
            // Only reached with cnt != 0, so the counter never wraps.
            cnt_n[i] = cnt[i] - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= '0;
      cnt        <= '0;
      period     <= '0;
      mode       <= '0;
      done_r     <= '0;
      any_done_r <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      period     <= period_n;
      mode       <= mode_n;
      done_r     <= done_n;
      any_done_r <= |done_n;
    end
  end

  assign busy     = state;
  assign done     = done_r;
  assign remain   = cnt;
  assign any_done = any_done_r;

endmodule

// File: tb/tb_delay_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_delay_timer_bank
//   Two instances: dut (RETRIG=0) and dut_r (RETRIG=1). Inputs are driven and
//   outputs sampled on the falling edge; cyc counts rising edges, so at a
//   falling edge cyc equals the index of the edge just taken. A start driven
//   at cyc=c is accepted on edge c+1 and its done is seen at cyc=c+N+2.
// ---------------------------------------------------------------------------
module tb_delay_timer_bank;

  localparam int NCH = 2;
  localparam int CW  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [NCH-1:0]    start, cancel, periodic, busy, done;
  logic [NCH*CW-1:0] count, remain;
  logic              any_done;

  logic [NCH-1:0]    start_r, cancel_r, periodic_r, busy_r, done_r;
  logic [NCH*CW-1:0] count_r, remain_r;
  logic              any_done_r;

  delay_timer_bank #(.NCH(NCH), .CW(CW), .RETRIG(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .periodic(periodic),
    .count(count), .busy(busy), .done(done), .remain(remain), .any_done(any_done)
  );

  delay_timer_bank #(.NCH(NCH), .CW(CW), .RETRIG(1'b1)) dut_r (
    .clk(clk), .rst(rst), .start(start_r), .cancel(cancel_r), .periodic(periodic_r),
    .count(count_r), .busy(busy_r), .done(done_r), .remain(remain_r), .any_done(any_done_r)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  // Expected cyc value at which each done pulse is observed.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_qr0[$];

  task automatic fail_line(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_err++;
    $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) fail_line(nm, act, exp);
  endtask

  // Done monitor: every done pulse must match the head of its channel queue;
  // an expected pulse that never shows up is reported once its time passes.
  always @(negedge clk) begin
    if (done[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin n_checks++; fail_line("done0_unexpected", 1, 0); end
      else check("done0_time", cyc, exp_q0.pop_front());
    end else if (exp_q0.size() > 0 && exp_q0[0] <= cyc) begin
      n_checks++; fail_line("done0_missing", 0, exp_q0.pop_front());
    end
    if (done[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin n_checks++; fail_line("done1_unexpected", 1, 0); end
      else check("done1_time", cyc, exp_q1.pop_front());
    end else if (exp_q1.size() > 0 && exp_q1[0] <= cyc) begin
      n_checks++; fail_line("done1_missing", 0, exp_q1.pop_front());
    end
    if (done_r[0] === 1'b1) begin
      if (exp_qr0.size() == 0) begin n_checks++; fail_line("rdone0_unexpected", 1, 0); end
      else check("rdone0_time", cyc, exp_qr0.pop_front());
    end else if (exp_qr0.size() > 0 && exp_qr0[0] <= cyc) begin
      n_checks++; fail_line("rdone0_missing", 0, exp_qr0.pop_front());
    end
    if (done_r[1] === 1'b1) begin
      n_checks++; fail_line("rdone1_unexpected", 1, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int ch, input logic [31:0] t);
    if (ch == 0) exp_q0.push_back(t);
    else         exp_q1.push_back(t);
  endtask

  task automatic drive_start(input int ch, input int n, input bit per);
    start[ch]            = 1'b1;
    periodic[ch]         = per;
    count[ch*CW +: CW]   = n[CW-1:0];
  endtask

  task automatic clear_inputs();
    start = '0; cancel = '0; periodic = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int ch;    // channel
    int n;     // loaded count
    int lat;   // expected edges from accepting edge to done edge
  } vec_t;

  vec_t vecs[5];

  task automatic run_oneshot(input vec_t v);
    logic [31:0] c;
    c = cyc;
    drive_start(v.ch, v.n, 1'b0);
    push_exp(v.ch, c + 1 + v.lat);
    step(1);
    clear_inputs();
    for (int j = 0; j < v.lat; j++) begin
      check($sformatf("busy_ch%0d_n%0d", v.ch, v.n), busy[v.ch], 1);
      check($sformatf("remain_ch%0d_n%0d", v.ch, v.n), remain[v.ch*CW +: CW], v.n - j);
      step(1);
    end
    check("done_at_expiry", done[v.ch], 1);
    check("any_done_at_expiry", any_done, 1);
    check("busy_falls_with_done", busy[v.ch], 0);
    check("remain_idle", remain[v.ch*CW +: CW], 0);
    step(1);
    check("done_one_cycle", done[v.ch], 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] c;
    vecs[0] = '{ch: 0, n: 5,   lat: 6};
    vecs[1] = '{ch: 0, n: 0,   lat: 1};
    vecs[2] = '{ch: 1, n: 255, lat: 256};
    vecs[3] = '{ch: 1, n: 1,   lat: 2};
    vecs[4] = '{ch: 0, n: 3,   lat: 4};

    rst = 1'b1;
    clear_inputs();
    count = '0;
    start_r = '0; cancel_r = '0; periodic_r = '0; count_r = '0;
    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_remain", remain, 0);
    check("rst_any_done", any_done, 0);
    check("rst_r_busy", busy_r, 0);
    check("rst_r_remain", remain_r, 0);
    rst = 1'b0;
    step(2);

    // One-shot vectors, including N=0 and N=255.
    for (int i = 0; i < 5; i++) begin
      run_oneshot(vecs[i]);
      step($urandom_range(1, 3));
    end

    // Periodic ch1 N=3, cancel on the third expiry edge.
    c = cyc;
    drive_start(1, 3, 1'b1);
    exp_q1.push_back(c + 5);
    exp_q1.push_back(c + 9);
    step(1);
    clear_inputs();
    step(4);
    check("per_done_first", done[1], 1);
    check("per_reload_remain", remain[CW +: CW], 3);
    check("per_still_busy", busy[1], 1);
    step(7);
    cancel[1] = 1'b1;
    step(1);
    cancel = '0;
    check("cancel_busy", busy[1], 0);
    check("cancel_remain", remain[CW +: CW], 0);
    check("cancel_no_done", done[1], 0);
    step(5);

    // Both channels started together: any_done at +3 and +8.
    c = cyc;
    drive_start(0, 2, 1'b0);
    drive_start(1, 7, 1'b0);
    exp_q0.push_back(c + 4);
    exp_q1.push_back(c + 9);
    step(1);
    clear_inputs();
    for (int j = 1; j <= 9; j++) begin
      step(1);
      check($sformatf("any_done_plus%0d", j), any_done, (j == 3 || j == 8) ? 1 : 0);
    end
    step(2);

    // RETRIG=0: start at remain=2 is ignored.
    c = cyc;
    drive_start(0, 5, 1'b0);
    exp_q0.push_back(c + 7);
    step(1);
    clear_inputs();
    step(3);
    check("noretrig_remain2", remain[0 +: CW], 2);
    drive_start(0, 9, 1'b0);
    step(1);
    clear_inputs();
    check("noretrig_ignored", remain[0 +: CW], 1);
    step(2);
    check("noretrig_done_kept", done[0], 1);
    step(14);

    // RETRIG=1: reload N=4 at remain=0, no done, then done 5 cycles later.
    start_r[0] = 1'b1; count_r[0 +: CW] = 8'd2;
    step(1);
    start_r = '0;
    step(2);
    check("retrig_remain0", remain_r[0 +: CW], 0);
    c = cyc;
    start_r[0] = 1'b1; count_r[0 +: CW] = 8'd4;
    exp_qr0.push_back(c + 6);
    step(1);
    start_r = '0;
    check("retrig_no_done", done_r[0], 0);
    check("retrig_reload", remain_r[0 +: CW], 4);
    check("retrig_busy", busy_r[0], 1);
    step(7);

    // rst mid-count at remain=3.
    drive_start(1, 6, 1'b0);
    step(1);
    clear_inputs();
    step(3);
    check("prerst_remain3", remain[CW +: CW], 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_remain", remain, 0);
    check("midrst_any_done", any_done, 0);
    step(10);
    run_oneshot('{ch: 1, n: 1, lat: 2});
    step(3);

    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);
    check("qr0_drained", exp_qr0.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
